// File: rtl/avalon_st_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// avalon_st_arbiter_pkg
// Shared types for the Avalon-ST packet arbiter.
//   arb_state_t : IDLE (no owner) / TRANSFER (grant_idx owns the output)
// ---------------------------------------------------------------------------
package avalon_st_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    TRANSFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/avalon_st_if.sv
// ---------------------------------------------------------------------------
// avalon_st_if
// Minimal Avalon-ST streaming interface carrying packets.
//   valid, sop, eop, data, empty : source -> sink
//   ready                        : sink -> source
// Modports:
//   master : drives the stream (source side)
//   slave  : receives the stream (sink side)
// ---------------------------------------------------------------------------
interface avalon_st_if #(
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2
);

  logic               valid;
  logic               ready;
  logic               sop;
  logic               eop;
  logic [DATA_W-1:0]  data;
  logic [EMPTY_W-1:0] empty;

  modport master (output valid, output sop, output eop, output data,
                  output empty, input ready);

  modport slave  (input valid, input sop, input eop, input data,
                  input empty, output ready);

endinterface

// File: rtl/rr_priority_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin picker. Returns the first requesting index when
// scanning rr_ptr, rr_ptr+1, ... wrapping at NUM_INPUTS-1 back to 0.
// Ports:
//   req     : request vector, one bit per source
//   rr_ptr  : index with highest priority this cycle (0..NUM_INPUTS-1)
//   winner  : selected index (meaningful only when any_req=1)
//   any_req : at least one request present
// ---------------------------------------------------------------------------
module rr_priority_picker #(
  parameter  int NUM_INPUTS = 4,
  localparam int GRANT_W    = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [GRANT_W-1:0]    rr_ptr,
  output logic [GRANT_W-1:0]    winner,
  output logic                  any_req
);

  logic [NUM_INPUTS-1:0] req_rot;
  logic [GRANT_W-1:0]    first_idx;
  logic                  found;
  logic [GRANT_W:0]      sum;

  // Rotate the requests so rr_ptr lands at bit 0. Doubling the vector
  // before shifting makes the rotation wrap for any NUM_INPUTS, including
  // counts that are not a power of two.
  always_comb begin
    req_rot = NUM_INPUTS'({req, req} >> rr_ptr);
  end

  // Find the lowest set bit of the rotated vector, i.e. the distance from
  // rr_ptr to the first requester.
  always_comb begin
    first_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (!found && req_rot[k]) begin
        first_idx = GRANT_W'(k);
        found     = 1'b1;
      end
    end
  end

  // Rotate back: add the distance to rr_ptr and wrap explicitly so the
  // winner never exceeds NUM_INPUTS-1.
  always_comb begin
    sum = {1'b0, rr_ptr} + {1'b0, first_idx};
    if (sum >= (GRANT_W+1)'(NUM_INPUTS)) begin
      sum = sum - (GRANT_W+1)'(NUM_INPUTS);
    end
    winner  = sum[GRANT_W-1:0];
    any_req = |req;
  end

endmodule

// File: rtl/avalon_st_packet_arbiter.sv
// ---------------------------------------------------------------------------
// avalon_st_packet_arbiter
// Shares one Avalon-ST output between NUM_INPUTS protocol-clean sources with
// packet-granular round-robin arbitration. A winner owns the output from its
// sop beat through its eop beat; packets never interleave.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   in_msg[]     : source streams (slave modport; ready driven here)
//   out_msg      : shared output stream (master modport; ready from sink)
//   grant_valid  : high while a packet is owned
//   grant_idx    : index of the current or last owner
//   dropped_beat : one-cycle pulse after a stray non-sop beat is flushed
// ---------------------------------------------------------------------------
module avalon_st_packet_arbiter
  import avalon_st_arbiter_pkg::*;
#(
  parameter  int NUM_INPUTS = 4,
  parameter  int DATA_W     = 32,
  parameter  int EMPTY_W    = 2,
  localparam int GRANT_W    = $clog2(NUM_INPUTS)
) (
  input  logic               clk,
  input  logic               rst,
  avalon_st_if.slave         in_msg [NUM_INPUTS],
  avalon_st_if.master        out_msg,
  output logic               grant_valid,
  output logic [GRANT_W-1:0] grant_idx,
  output logic               dropped_beat
);

  arb_state_t            state;
  logic [GRANT_W-1:0]    rr_ptr;
  logic [GRANT_W-1:0]    winner;
  logic                  any_req;

  logic [NUM_INPUTS-1:0] in_valid;
  logic [NUM_INPUTS-1:0] in_sop;
  logic [NUM_INPUTS-1:0] in_eop;
  logic [DATA_W-1:0]     in_data  [NUM_INPUTS];
  logic [EMPTY_W-1:0]    in_empty [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] req;
  logic [NUM_INPUTS-1:0] flush;
  logic [NUM_INPUTS-1:0] ready_vec;

  logic                  out_valid;
  logic                  out_sop;
  logic                  out_eop;
  logic [DATA_W-1:0]     out_data;
  logic [EMPTY_W-1:0]    out_empty;

  // Interface arrays can only be indexed by constants, so gather every
  // source into plain arrays that the mux can select with grant_idx.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_src
    assign in_valid[i]     = in_msg[i].valid;
    assign in_sop[i]       = in_msg[i].sop;
    assign in_eop[i]       = in_msg[i].eop;
    assign in_data[i]      = in_msg[i].data;
    assign in_empty[i]     = in_msg[i].empty;
    assign in_msg[i].ready = ready_vec[i];
  end

  // Only a sop beat can start a packet; any other head beat seen while idle
  // is garbage and gets drained so it cannot block its source forever.
  assign req   = in_valid & in_sop;
  assign flush = in_valid & ~in_sop;

  rr_priority_picker #(
    .NUM_INPUTS (NUM_INPUTS)
  ) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // Output mux and ready steering. While a packet is owned the output is a
  // straight pass-through of the owner, with data and empty cleaned up on
  // beats where they carry no meaning. While idle nothing reaches the
  // output; only stray beats are acknowledged, and the decision cycle
  // accepts nothing from the requesters.
  always_comb begin
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_data  = '0;
    out_empty = '0;
    ready_vec = '0;
    if (state == TRANSFER) begin
      out_valid = in_valid[grant_idx];
      out_sop   = in_sop[grant_idx];
      out_eop   = in_eop[grant_idx];
      out_data  = in_valid[grant_idx] ? in_data[grant_idx] : '0;
      out_empty = in_eop[grant_idx] ? in_empty[grant_idx] : '0;
      ready_vec[grant_idx] = out_msg.ready;
    end else begin
      ready_vec = flush;
    end
  end

  assign out_msg.valid = out_valid;
  assign out_msg.sop   = out_sop;
  assign out_msg.eop   = out_eop;
  assign out_msg.data  = out_data;
  assign out_msg.empty = out_empty;

  assign grant_valid = (state == TRANSFER);

  // Arbiter state machine. The winner is registered in the idle cycle, so
  // the packet starts flowing one cycle later. Ownership ends on the
  // accepted eop beat and the pointer moves just past the owner, which
  // gives round-robin fairness; grant_idx keeps the last owner. A reset in
  // the middle of a packet simply abandons it downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant_idx    <= '0;
      dropped_beat <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dropped_beat <= |flush;
          if (any_req) begin
            grant_idx <= winner;
            state     <= TRANSFER;
          end
        end
        TRANSFER: begin
          dropped_beat <= 1'b0;
          if (out_valid && out_msg.ready && out_eop) begin
            state  <= IDLE;
            rr_ptr <= (grant_idx == GRANT_W'(NUM_INPUTS - 1)) ? '0
                                                             : grant_idx + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_st_packet_arbiter.sv
// ---------------------------------------------------------------------------
// tb_avalon_st_packet_arbiter
// Directed bench for avalon_st_packet_arbiter with a packet-level model that
// predicts every output each cycle, plus literal expectations on the
// sequence of beats delivered downstream.
// ---------------------------------------------------------------------------
module tb_avalon_st_packet_arbiter;

  localparam int N  = 4;
  localparam int GW = 2;
  localparam int DW = 32;
  localparam int EW = 2;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
    logic [EW-1:0] empty;
    logic [3:0]    gap;
  } beat_t;

  localparam logic [31:0] T2_DATA [10] = '{32'h020, 32'h021, 32'h120, 32'h121,
                                           32'h220, 32'h221, 32'h320, 32'h321,
                                           32'h030, 32'h031};
  localparam logic [31:0] T2_GIDX [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

  logic clk = 1'b0;
  logic rst;

  logic [N-1:0]  tb_valid;
  logic [N-1:0]  tb_sop;
  logic [N-1:0]  tb_eop;
  logic [DW-1:0] tb_data  [N];
  logic [EW-1:0] tb_empty [N];
  logic          tb_out_ready;
  logic [N-1:0]  dut_ready;

  logic          grant_valid;
  logic [GW-1:0] grant_idx;
  logic          dropped_beat;

  beat_t src_q [N][$];
  int    gap_cnt [N];
  logic  rdy_pat [$];

  int    checks = 0;
  int    errors = 0;
  bit    check_en = 1'b0;

  int    model_owner = -1;
  int    model_ptr   = 0;
  int    model_last  = 0;
  bit    model_drop  = 1'b0;

  logic [31:0] log_data [$];
  logic [31:0] log_gidx [$];
  logic        log_sop  [$];
  logic        log_eop  [$];
  int          drop_count = 0;

  avalon_st_if #(.DATA_W(DW), .EMPTY_W(EW)) in_if [N] ();
  avalon_st_if #(.DATA_W(DW), .EMPTY_W(EW)) out_if ();

  for (genvar g = 0; g < N; g++) begin : g_src
    assign in_if[g].valid = tb_valid[g];
    assign in_if[g].sop   = tb_sop[g];
    assign in_if[g].eop   = tb_eop[g];
    assign in_if[g].data  = tb_data[g];
    assign in_if[g].empty = tb_empty[g];
    assign dut_ready[g]   = in_if[g].ready;
  end
  assign out_if.ready = tb_out_ready;

  avalon_st_packet_arbiter #(
    .NUM_INPUTS (N),
    .DATA_W     (DW),
    .EMPTY_W    (EW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_msg       (in_if),
    .out_msg      (out_if),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .dropped_beat (dropped_beat)
  );

  always #5 clk = ~clk;

  // One comparison: count it, and report it when actual and required differ.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() != 0) e = 1'b0;
    end
    return e;
  endfunction

  // Queue a packet of nbeats on a source; data encodes source, packet, beat.
  task automatic push_packet(input int src, input int pkt, input int nbeats,
                             input int gap_beat, input int gap_len);
    beat_t b;
    for (int k = 0; k < nbeats; k++) begin
      b.sop   = (k == 0);
      b.eop   = (k == nbeats - 1);
      b.data  = 32'(src * 256 + pkt * 16 + k);
      b.empty = b.eop ? EW'(src) : 2'd3;
      b.gap   = (k == gap_beat) ? 4'(gap_len) : 4'd0;
      src_q[src].push_back(b);
    end
  endtask

  // Present each source's head beat; idle sources drive junk with valid low.
  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && gap_cnt[i] == 0) begin
        tb_valid[i] = 1'b1;
        tb_sop[i]   = src_q[i][0].sop;
        tb_eop[i]   = src_q[i][0].eop;
        tb_data[i]  = src_q[i][0].data;
        tb_empty[i] = src_q[i][0].empty;
      end else begin
        tb_valid[i] = 1'b0;
        tb_sop[i]   = 1'b0;
        tb_eop[i]   = 1'b0;
        tb_data[i]  = 32'hDEAD_BEEF;
        tb_empty[i] = 2'd3;
      end
    end
    tb_out_ready = (rdy_pat.size() > 0) ? rdy_pat[0] : 1'b1;
  endtask

  // Advance one clock: capture handshakes, then retire accepted beats.
  task automatic applyStimulus();
    logic [N-1:0] pop;
    @(negedge clk);
    pop = tb_valid & dut_ready;
    @(posedge clk);
    #1;
    if (rdy_pat.size() > 0) void'(rdy_pat.pop_front());
    for (int i = 0; i < N; i++) begin
      if (pop[i] && src_q[i].size() > 0) begin
        void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) gap_cnt[i] = int'(src_q[i][0].gap);
      end else if (gap_cnt[i] > 0) begin
        gap_cnt[i]--;
      end
    end
    drive_inputs();
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int n = 0;
    while (!(all_empty() && model_owner < 0 && rdy_pat.size() == 0) && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput({name, "_done"}, 32'(n < budget), 32'd1);
    applyStimulus();
    applyStimulus();
  endtask

  // Packet-level model: who owns the output, where the fairness pointer is,
  // and whether a stray beat was drained last cycle. Outputs are predicted
  // from that and the current inputs, then the model steps over the edge.
  initial begin
    logic          e_valid, e_sop, e_eop;
    logic [DW-1:0] e_data;
    logic [EW-1:0] e_empty;
    logic [N-1:0]  e_ready;
    int            win;
    int            idx;
    forever begin
      @(negedge clk);
      e_valid = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_data = '0; e_empty = '0;
      e_ready = '0;
      for (int i = 0; i < N; i++) begin
        if (model_owner < 0) begin
          e_ready[i] = tb_valid[i] & ~tb_sop[i];
        end else if (i == model_owner) begin
          e_valid    = tb_valid[i];
          e_sop      = tb_sop[i];
          e_eop      = tb_eop[i];
          e_data     = tb_valid[i] ? tb_data[i] : '0;
          e_empty    = tb_eop[i] ? tb_empty[i] : '0;
          e_ready[i] = tb_out_ready;
        end
      end
      if (check_en) begin
        checkOutput("out_valid", 32'(out_if.valid), 32'(e_valid));
        checkOutput("out_sop", 32'(out_if.sop), 32'(e_sop));
        checkOutput("out_eop", 32'(out_if.eop), 32'(e_eop));
        checkOutput("out_data", out_if.data, e_data);
        checkOutput("out_empty", 32'(out_if.empty), 32'(e_empty));
        checkOutput("in_ready", 32'(dut_ready), 32'(e_ready));
        checkOutput("grant_valid", 32'(grant_valid), 32'(model_owner >= 0));
        checkOutput("grant_idx", 32'(grant_idx), 32'(model_last));
        checkOutput("dropped_beat", 32'(dropped_beat), 32'(model_drop));
        if (out_if.valid && tb_out_ready) begin
          log_data.push_back(out_if.data);
          log_gidx.push_back(32'(grant_idx));
          log_sop.push_back(out_if.sop);
          log_eop.push_back(out_if.eop);
        end
        if (dropped_beat) drop_count++;
      end
      if (rst) begin
        model_owner = -1;
        model_ptr   = 0;
        model_last  = 0;
        model_drop  = 1'b0;
      end else if (model_owner < 0) begin
        model_drop = |(tb_valid & ~tb_sop);
        win = -1;
        for (int k = 0; k < N; k++) begin
          idx = (model_ptr + k) % N;
          if (win < 0 && tb_valid[GW'(idx)] && tb_sop[GW'(idx)]) win = idx;
        end
        if (win >= 0) begin
          model_owner = win;
          model_last  = win;
        end
      end else begin
        model_drop = 1'b0;
        if (e_valid && tb_out_ready && e_eop) begin
          model_ptr   = (model_owner + 1) % N;
          model_owner = -1;
        end
      end
    end
  end

  initial begin
    int    base;
    int    dbase;
    int    n;
    beat_t stray;

    for (int i = 0; i < N; i++) gap_cnt[i] = 0;
    rst = 1'b1;
    drive_inputs();
    repeat (3) applyStimulus();
    rst = 1'b0;
    check_en = 1'b1;
    $display("[TB] reset released");
    checkOutput("rst_grant_valid", 32'(grant_valid), 32'd0);
    checkOutput("rst_grant_idx", 32'(grant_idx), 32'd0);
    checkOutput("rst_ready", 32'(dut_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_if.valid), 32'd0);

    // Single 3-beat packet from source 2.
    base = log_data.size();
    push_packet(2, 0, 3, -1, 0);
    drive_inputs();
    run_until_idle("t1", 40);
    checkOutput("t1_beats", 32'(log_data.size() - base), 32'd3);
    for (int k = 0; k < 3; k++) begin
      checkOutput("t1_data", log_data[base + k], 32'h200 + 32'(k));
      checkOutput("t1_gidx", log_gidx[base + k], 32'd2);
    end
    checkOutput("t1_sop", 32'(log_sop[base]), 32'd1);
    checkOutput("t1_eop", 32'(log_eop[base + 2]), 32'd1);

    // Stray non-sop head beat on source 3 while idle.
    base  = log_data.size();
    dbase = drop_count;
    stray.sop = 1'b0; stray.eop = 1'b0; stray.data = 32'h3F0;
    stray.empty = 2'd0; stray.gap = 4'd0;
    src_q[3].push_back(stray);
    drive_inputs();
    run_until_idle("t4", 20);
    checkOutput("t4_drops", 32'(drop_count - dbase), 32'd1);
    checkOutput("t4_beats", 32'(log_data.size() - base), 32'd0);

    // Backpressure during a 4-beat packet from source 1.
    base = log_data.size();
    push_packet(1, 0, 4, -1, 0);
    rdy_pat.push_back(1'b1);
    rdy_pat.push_back(1'b1);
    rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b1);
    drive_inputs();
    run_until_idle("t3", 40);
    checkOutput("t3_beats", 32'(log_data.size() - base), 32'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput("t3_data", log_data[base + k], 32'h100 + 32'(k));
    end

    // Reset after beat 2 of a 4-beat packet from source 3.
    base = log_data.size();
    push_packet(3, 0, 4, -1, 0);
    drive_inputs();
    n = 0;
    while (log_data.size() < base + 2 && n < 40) begin
      applyStimulus();
      n++;
    end
    checkOutput("t5_reach", 32'(n < 40), 32'd1);
    rst = 1'b1;
    src_q[3].delete();
    gap_cnt[3] = 0;
    drive_inputs();
    applyStimulus();
    rst = 1'b0;
    checkOutput("t5_grant_valid", 32'(grant_valid), 32'd0);
    checkOutput("t5_ready", 32'(dut_ready), 32'd0);
    checkOutput("t5_out_valid", 32'(out_if.valid), 32'd0);
    checkOutput("t5_grant_idx", 32'(grant_idx), 32'd0);
    base = log_data.size();
    push_packet(1, 1, 1, -1, 0);
    push_packet(3, 1, 1, -1, 0);
    drive_inputs();
    run_until_idle("t5", 40);
    checkOutput("t5_beats", 32'(log_data.size() - base), 32'd2);
    checkOutput("t5_first", log_data[base], 32'h110);
    checkOutput("t5_second", log_data[base + 1], 32'h310);

    // All four sources request continuously with 2-beat packets.
    base = log_data.size();
    push_packet(0, 2, 2, -1, 0);
    push_packet(1, 2, 2, -1, 0);
    push_packet(2, 2, 2, 1, 1);
    push_packet(3, 2, 2, -1, 0);
    push_packet(0, 3, 2, -1, 0);
    drive_inputs();
    run_until_idle("t2", 80);
    checkOutput("t2_beats", 32'(log_data.size() - base), 32'd10);
    for (int k = 0; k < 10; k++) begin
      checkOutput("t2_data", log_data[base + k], T2_DATA[k]);
      checkOutput("t2_gidx", log_gidx[base + k], T2_GIDX[k]);
    end

    // Simultaneous single-beat packets from sources 0 and 1.
    base = log_data.size();
    push_packet(0, 4, 1, -1, 0);
    push_packet(1, 4, 1, -1, 0);
    drive_inputs();
    run_until_idle("t6", 40);
    checkOutput("t6_beats", 32'(log_data.size() - base), 32'd2);
    checkOutput("t6_first", log_data[base], 32'h140);
    checkOutput("t6_first_gidx", log_gidx[base], 32'd1);
    checkOutput("t6_second", log_data[base + 1], 32'h040);
    checkOutput("t6_second_gidx", log_gidx[base + 1], 32'd0);
    for (int k = 0; k < 2; k++) begin
      checkOutput("t6_sop", 32'(log_sop[base + k]), 32'd1);
      checkOutput("t6_eop", 32'(log_eop[base + k]), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
